uart_tx_arbiter: RTL and testbench

Shares the byte-serial UART `Transmitter` between up to `NREQ` requesters. Each requester offers a byte over a valid/ready handshake, and the block grants them in round-robin order. For each granted byte it issues a one-cycle `EN` pulse with `DataIN` held stable. It then blocks new grants until the frame and a guard gap have elapsed, because the transmitter has no busy/done output. It sits between the command/packet layer and the transmitter, on the same clock.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM state type and transmitter frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    FRAME,
    GAP
  } tx_arb_state_t;

  // Clocks the byte-serial transmitter needs for one frame (start + 8 data + stop).
  localparam int unsigned UART_FRAME_CYCLES = 10;
  localparam int unsigned UART_DATA_W       = 8;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter bundle for uart_tx_arbiter.
//   req_valid/req_data/req_ready : per-requester byte handshake
//   pause                        : hold off new grants
//   tx_en/tx_data                : drive the transmitter EN / DataIN
//   busy/grant_id/frames_sent    : status
// slave modport is the arbiter side; master modport is the requester/system side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import uart_pkg::*;

  localparam int unsigned IdxW = $clog2(NREQ);

  logic [NREQ-1:0]                  req_valid;
  logic [NREQ-1:0][UART_DATA_W-1:0] req_data;
  logic [NREQ-1:0]                  req_ready;
  logic                             pause;
  logic                             tx_en;
  logic [UART_DATA_W-1:0]           tx_data;
  logic                             busy;
  logic [IdxW-1:0]                  grant_id;
  logic [15:0]                      frames_sent;

  modport slave (
    input  req_valid, req_data, pause,
    output req_ready, tx_en, tx_data, busy, grant_id, frames_sent
  );

  modport master (
    output req_valid, req_data, pause,
    input  req_ready, tx_en, tx_data, busy, grant_id, frames_sent
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : highest-priority index this cycle
//   gnt_o     : one-hot grant (first set bit searching upward from ptr_i, wrapping)
//   gnt_idx_o : index of the granted bit (0 when nothing is requested)
//   valid_o   : any request present
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            valid_o
);

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    valid_o   = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one byte-serial UART transmitter between NREQ requesters.
// The transmitter has no busy/done, so after each EN pulse the block times the frame
// plus a guard gap before accepting the next byte.
//   CLK   : clock, rising edge
//   Reset : asynchronous, active-low
//   bus   : uart_tx_arbiter_if.slave (requester handshakes, pause, tx_en/tx_data, status)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned FRAME_CYCLES = UART_FRAME_CYCLES,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                 CLK,
  input  logic                 Reset,
  uart_tx_arbiter_if.slave     bus
);

  localparam int unsigned IdxW = $clog2(NREQ);
  localparam int unsigned CntW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

  tx_arb_state_t          state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                   tx_en_q, tx_en_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic                   busy_q, busy_d;
  logic [IdxW-1:0]        grant_id_q, grant_id_d;
  logic [15:0]            frames_sent_q, frames_sent_d;

  logic [NREQ-1:0] gnt;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            take;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req_i     (bus.req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .valid_o   (gnt_valid)
  );

  // Reset gates the handshake so nothing is accepted while the block is held in reset.
  assign take          = Reset && (state_q == IDLE) && !bus.pause && gnt_valid;
  assign bus.req_ready = take ? gnt : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    tx_en_d       = 1'b0;
    tx_data_d     = tx_data_q;
    busy_d        = busy_q;
    grant_id_d    = grant_id_q;
    frames_sent_d = frames_sent_q;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          tx_data_d  = bus.req_data[gnt_idx];
          grant_id_d = gnt_idx;
          rr_ptr_d   = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
          tx_en_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        frames_sent_d = frames_sent_q + 16'd1;
        // The LAUNCH cycle is the first of the FRAME_CYCLES busy cycles.
        cnt_d         = CntW'(FRAME_CYCLES - 2);
        state_d       = FRAME;
      end
      FRAME: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES > 0) begin
            cnt_d   = CntW'(GAP_CYCLES - 1);
            state_d = GAP;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      tx_en_q       <= 1'b0;
      tx_data_q     <= '0;
      busy_q        <= 1'b0;
      grant_id_q    <= '0;
      frames_sent_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      tx_en_q       <= tx_en_d;
      tx_data_q     <= tx_data_d;
      busy_q        <= busy_d;
      grant_id_q    <= grant_id_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  assign bus.tx_en       = tx_en_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.frames_sent = frames_sent_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a timing-arithmetic reference model checks every cycle of the
// default instance; a second instance with GAP_CYCLES=0 drives a transmitter model whose line
// is decoded back into bytes.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int F = 10;
  localparam int G = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst0_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus ();
  uart_tx_arbiter_if #(.NREQ(4)) bus0 ();

  uart_tx_arbiter #(.NREQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(1)) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  uart_tx_arbiter #(.NREQ(4), .FRAME_CYCLES(10), .GAP_CYCLES(0)) dut0 (
    .CLK   (clk),
    .Reset (rst0_n),
    .bus   (bus0)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model (cycle arithmetic on grant times) ----------------
  int          cyc = 0;
  bit          model_on = 1'b0;
  int          m_launch, m_free, m_inc, m_ptr, m_gid;
  logic [7:0]  m_data;
  logic [15:0] m_frames;
  int          lg_q[$];
  int          lc_q[$];

  task automatic model_reset();
    m_launch = -100;
    m_free   = 0;
    m_inc    = -100;
    m_ptr    = 0;
    m_gid    = 0;
    m_data   = 8'h00;
    m_frames = 16'h0000;
  endtask

  task automatic model_check();
    logic [3:0] v;
    logic [3:0] exp_rdy;
    int g;
    v = bus.req_valid;
    if (cyc == m_inc) m_frames = m_frames + 16'd1;
    check_eq("tx_en", 32'(bus.tx_en), 32'(cyc == m_launch));
    check_eq("busy", 32'(bus.busy), 32'(cyc >= m_launch && cyc < m_free));
    check_eq("tx_data", 32'(bus.tx_data), 32'(m_data));
    check_eq("grant_id", 32'(bus.grant_id), 32'(m_gid));
    check_eq("frames_sent", 32'(bus.frames_sent), 32'(m_frames));
    exp_rdy = 4'b0000;
    if (cyc >= m_free && !bus.pause && v != 4'b0000) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy[g] = 1'b1;
      m_data   = bus.req_data[g];
      m_gid    = g;
      m_ptr    = (g + 1) % N;
      m_launch = cyc + 1;
      m_free   = cyc + 1 + F + G;
      m_inc    = cyc + 2;
    end
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    if (bus.tx_en) begin
      lg_q.push_back(int'(bus.grant_id));
      lc_q.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_on) model_check();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_launches(input int n, input int budget);
    int b = 0;
    while (lg_q.size() < n && b < budget) begin
      tick();
      b++;
    end
    check_eq("launch_timeout", 32'(lg_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int b = 0;
    bus.req_valid = 4'b0000;
    tick();
    while (bus.busy && b < 40) begin
      tick();
      b++;
    end
    check_eq("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // ---------------- GAP_CYCLES=0 instance: transmitter model + line decoder ----------------
  logic [9:0] tx_sh;
  int         tx_bits;
  logic       line;
  bit         g0_done = 1'b0;
  logic [7:0] g0_tab [4] = '{8'hC3, 8'h5A, 8'h81, 8'h7E};

  always @(posedge clk or negedge rst0_n) begin
    if (!rst0_n) begin
      tx_sh   <= 10'h3FF;
      tx_bits <= 0;
    end else if (bus0.tx_en) begin
      tx_sh   <= {1'b0, bus0.tx_data, 1'b1};
      tx_bits <= 10;
    end else if (tx_bits > 0) begin
      tx_sh   <= {tx_sh[8:0], 1'b1};
      tx_bits <= tx_bits - 1;
    end
  end
  assign line = (tx_bits > 0) ? tx_sh[9] : 1'b1;

  initial begin
    int c0 = 0;
    int last = -1;
    int rx_cnt = 0;
    int frame = 0;
    logic [7:0] rx_byte = 8'h00;
    bus0.pause     = 1'b0;
    bus0.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) bus0.req_data[i] = g0_tab[i];
    repeat (2) @(posedge clk);
    #1 rst0_n = 1'b1;
    while (!g0_done) begin
      @(negedge clk);
      c0++;
      if (bus0.tx_en) begin
        if (last >= 0) check_eq("gap0_period", 32'(c0 - last), 32'd11);
        last = c0;
      end
      if (rx_cnt == 0) begin
        if (line == 1'b0) rx_cnt = 1;
      end else if (rx_cnt <= 8) begin
        rx_byte = {rx_byte[6:0], line};
        rx_cnt++;
      end else begin
        check_eq("gap0_stop", 32'(line), 32'd1);
        check_eq("gap0_byte", 32'(rx_byte), 32'(g0_tab[frame % 4]));
        frame++;
        rx_cnt = 0;
        if (frame == 8) g0_done = 1'b1;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bus.req_valid = 4'b0000;
    bus.req_data  = '0;
    bus.pause     = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    check_eq("rst_tx_en", 32'(bus.tx_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check_eq("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check_eq("rst_frames", 32'(bus.frames_sent), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    model_on = 1'b1;

    // Round-robin with all requesters valid
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'(8'h10 + i);
    bus.req_valid = 4'b1111;
    wait_launches(5, 100);
    if (lg_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) check_eq("rr_order", 32'(lg_q[i]), 32'(i % N));
      for (int i = 1; i < 5; i++) check_eq("rr_period", 32'(lc_q[i] - lc_q[i-1]), 32'd12);
    end

    // Skip: pointer is 1 after serving requester 0
    wait_idle();
    lg_q.delete();
    lc_q.delete();
    bus.req_data[0] = 8'h55;
    bus.req_data[3] = 8'h66;
    bus.req_valid   = 4'b1001;
    wait_launches(2, 60);
    if (lg_q.size() >= 2) begin
      check_eq("skip_first", 32'(lg_q[0]), 32'd3);
      check_eq("skip_second", 32'(lg_q[1]), 32'd0);
    end

    // Pause raised mid-frame
    lg_q.delete();
    lc_q.delete();
    bus.req_valid = 4'b1111;
    wait_launches(1, 60);
    repeat (3) tick();
    bus.pause = 1'b1;
    n = lg_q.size();
    repeat (30) tick();
    check_eq("pause_no_launch", 32'(lg_q.size()), 32'(n));
    bus.pause = 1'b0;
    tick();
    tick();
    check_eq("pause_resume", 32'(lg_q.size()), 32'(n + 1));

    // frames_sent wrap
    wait_idle();
    force dut.frames_sent_q = 16'hFFFF;
    m_frames = 16'hFFFF;
    tick();
    release dut.frames_sent_q;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = 4'b0000;
    repeat (3) tick();
    check_eq("wrap", 32'(bus.frames_sent), 32'd0);

    // Reset in the middle of a frame
    wait_idle();
    lg_q.delete();
    lc_q.delete();
    bus.req_data[0] = 8'h77;
    bus.req_valid   = 4'b0001;
    wait_launches(1, 40);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_tx_en", 32'(bus.tx_en), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("midrst_frames", 32'(bus.frames_sent), 32'd0);
    model_on = 1'b0;
    repeat (2) tick();
    bus.req_data[0] = 8'hA5;
    bus.req_valid   = 4'b0001;
    rst_n = 1'b1;
    model_reset();
    m_free = cyc;
    model_on = 1'b1;
    #1;
    check_eq("rel_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    check_eq("rel_tx_en", 32'(bus.tx_en), 32'd1);
    check_eq("rel_tx_data", 32'(bus.tx_data), 32'hA5);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 3) == 0) bus.req_valid = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) bus.req_data[$urandom_range(0, 3)] = 8'($urandom);
      bus.pause = ($urandom_range(0, 9) == 0);
      tick();
    end
    bus.pause = 1'b0;

    begin
      int b = 0;
      while (!g0_done && b < 500) begin
        @(posedge clk);
        b++;
      end
      check_eq("gap0_timeout", 32'(g0_done), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
